dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//  Posted-write buffer between the mips core data port and the dmem block. Stores are
//  queued and retired to dmem in cycles where the core does not use the memory port.
//  Loads see the youngest buffered data for their word (store-to-load forwarding).
//  The core stalls only when it issues a store while the buffer is full.
// PARAMETERS
//  DEPTH   4   number of buffer entries; power of 2, >= 2
//  ADDR_W  10  dmem word-address width; matches alu_out[9:0]
//  DATA_W  32  data width
// PORTS
//  clock     in   1       single clock for the block
//  reset     in   1       asynchronous, active-low; clears all state
//  cpu_we    in   1       core store request this cycle
//  cpu_re    in   1       core load request this cycle; never asserted with cpu_we
//  cpu_addr  in   ADDR_W  core data address
//  cpu_wd    in   DATA_W  core store data
//  cpu_rd    out  DATA_W  load data; forwarded from buffer or taken from mem_rd
//  stall     out  1       core must hold its store and retry next cycle
//  mem_we    out  1       dmem write enable; high only for a drain
//  mem_addr  out  ADDR_W  dmem address: cpu_addr on a load, head entry on a drain
//  mem_wd    out  DATA_W  dmem write data: head entry data
//  mem_rd    in   DATA_W  dmem asynchronous read data
//  empty     out  1       no valid entries; software fence / debug probe
// BEHAVIOUR
//  - Reset (reset=0, async): valid[] cleared, head=tail=0, count=0.
//    Outputs: empty=1, stall=0, mem_we=0.
//  - Storage: circular FIFO with head (oldest) and tail pointers; count is $clog2(DEPTH)+1
//    bits wide. Pointers wrap modulo DEPTH.
//  - drain = !empty && !cpu_re && (!cpu_we || full).
//    On a drain: mem_we=1, mem_addr/mem_wd = head entry; head advances at the clock edge.
//  - Enqueue = cpu_we && !full. The entry is written at tail, tail advances, and the
//    store completes in 0 added cycles.
//  - stall = cpu_we && full (combinational). That same cycle drains the head entry, so the
//    retried store is accepted next cycle. Max stall per store is 1 cycle.
//  - Load (cpu_re=1): mem_addr=cpu_addr and mem_we=0, so no drain that cycle.
//    Priority-match all valid entries on address:
//      - hit: cpu_rd = data of the youngest match;
//      - miss: cpu_rd = mem_rd.
//    Zero cycles of latency.
//  - Idle cycles (no cpu_we/cpu_re) drain one entry per cycle until empty.
//  - Simultaneous enqueue and drain cannot occur; with cpu_we high, drain only fires when full.
//  - With cpu_re=0 and cpu_we=0, mem_addr = head address. cpu_rd = mem_rd whenever cpu_re=0.
//  - Reset mid-operation discards all pending stores; they are never written to dmem.
//  - Addresses are word granular; no byte enables.
// CONFIGURATION
//  STORE_COALESCE_EN defined:
//    - A store whose address matches a valid, non-head entry overwrites that entry's data
//      in place; tail and count are unchanged.
//    - This coalescing is accepted even when full, with stall=0.
//  STORE_COALESCE_EN undefined:
//    - Every store allocates a new entry.
//    - Duplicate addresses drain in program order; the final dmem value is the last store.
// STRUCTURE
//  - global_types package gets:
//      - sb_entry_t: struct {valid, addr[ADDR_W], data[DATA_W]};
//      - localparam SB_DEPTH_DEFAULT = 4.
//    logic32 is reused.
//  - One sub-module, sb_forward_match: combinational youngest-match priority select over
//    entries, ordered relative to the tail pointer; outputs hit and data.
//  - The FIFO control and the CONFIGURATION logic stay in this module.
// TESTING
//  1 Reset:
//      drive reset=0 mid-run with 3 entries queued;
//      -> empty=1, mem_we=0, and those addresses never written.
//  2 Store then idle:
//      store 0x0A5 <- 0xDEADBEEF, then one idle cycle;
//      -> mem_we=1, mem_addr=0x0A5, mem_wd=0xDEADBEEF; empty=1 after.
//  3 Forwarding:
//      store 0x010 <- 0x1111, store 0x010 <- 0x2222, then load 0x010;
//      -> cpu_rd=0x2222 with dmem still holding the old value.
//  4 Full stall:
//      DEPTH=4 stores back-to-back to 0x000..0x004;
//      -> 5th store sees stall=1 for exactly 1 cycle while 0x000 drains, then is accepted.
//  5 Miss path:
//      load 0x3FF with buffer empty and dmem[0x3FF]=0x00C0FFEE;
//      -> cpu_rd=0x00C0FFEE, mem_we=0.
//  6 Coalesce:
//      with STORE_COALESCE_EN, stores to 0x020, 0x021, 0x021 while loads block drains;
//      -> count=2 and only 2 dmem writes occur.
//    Without the macro: count=3, 3 writes in order, final dmem[0x021] = last data.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the dmem store buffer: entry record, default depth and
// the 32-bit word type used across the core data path.
package dmem_store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 10;
  localparam int SB_DATA_W        = 32;

  typedef logic [31:0] logic32;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic32               data;
  } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_forward_match.sv
// sb_forward_match: combinational youngest-match select over the store buffer.
// Entries are scanned oldest-to-youngest starting at the tail pointer, so a
// later match overrides an earlier one and the youngest matching entry wins.
module sb_forward_match
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t            entries [DEPTH],
  input  logic [PTR_W-1:0]     tail,
  input  logic [SB_ADDR_W-1:0] addr,
  output logic                 hit,
  output logic32               data
);

  logic [PTR_W-1:0] idx_s;

  // Walk entries in age order from tail; the last valid match is the youngest.
  always_comb begin
    hit   = 1'b0;
    data  = 32'h0000_0000;
    idx_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = tail + PTR_W'(k);
      if (entries[idx_s].valid && (entries[idx_s].addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx_s].data;
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write FIFO between the core data port and dmem.
// Stores are queued and retired to dmem on cycles where the core leaves the
// memory port free; loads forward the youngest buffered data for their word.
// Optional feature macro: STORE_COALESCE_EN (merge a store into a matching
// valid non-head entry instead of allocating a new one).
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic             full_s;
  logic             empty_s;
  logic             drain_s;
  logic             enq_s;
  logic             coal_hit_s;
  logic [PTR_W-1:0] coal_idx_s;
  logic             fwd_hit_s;
  logic32           fwd_data_s;

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

`ifdef STORE_COALESCE_EN
  // Find a valid non-head entry holding the store address; the head is
  // excluded because it may be draining this very cycle.
  always_comb begin
    coal_hit_s = 1'b0;
    coal_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cpu_we && entries_r[i].valid && (entries_r[i].addr == cpu_addr) &&
          (PTR_W'(i) != head_r)) begin
        coal_hit_s = 1'b1;
        coal_idx_s = PTR_W'(i);
      end else begin
        coal_hit_s = coal_hit_s;
        coal_idx_s = coal_idx_s;
      end
    end
  end
`else
  assign coal_hit_s = 1'b0;
  assign coal_idx_s = '0;
`endif

  assign enq_s   = cpu_we && !full_s && !coal_hit_s;
  assign drain_s = !empty_s && !cpu_re && (!cpu_we || full_s);

  sb_forward_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_forward_match (
    .entries (entries_r),
    .tail    (tail_r),
    .addr    (cpu_addr),
    .hit     (fwd_hit_s),
    .data    (fwd_data_s)
  );

  // Drive the core and dmem ports; loads own the address bus, otherwise head.
  always_comb begin
    stall  = cpu_we && full_s && !coal_hit_s;
    mem_we = drain_s;
    mem_wd = entries_r[head_r].data;
    empty  = empty_s;
    if (cpu_re) begin
      mem_addr = cpu_addr;
    end else begin
      mem_addr = entries_r[head_r].addr;
    end
    if (cpu_re && fwd_hit_s) begin
      cpu_rd = fwd_data_s;
    end else begin
      cpu_rd = mem_rd;
    end
  end

  // FIFO state: enqueue at tail, coalesce in place, retire head on drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_s) begin
        entries_r[tail_r].valid <= 1'b1;
        entries_r[tail_r].addr  <= cpu_addr;
        entries_r[tail_r].data  <= cpu_wd;
        tail_r                  <= tail_r + PTR_W'(1);
      end
      if (coal_hit_s) begin
        entries_r[coal_idx_s].data <= cpu_wd;
      end
      if (drain_s) begin
        entries_r[head_r].valid <= 1'b0;
        head_r                  <= head_r + PTR_W'(1);
      end
      case ({enq_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: stimulus pushes expected dmem writes
// and load data into queues; a negedge monitor pops and compares them.
module tb_dmem_store_buffer;

  logic        clock;
  logic        reset;
  logic        cpu_we;
  logic        cpu_re;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        stall;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        empty;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] dmem [1024];

  int checks   = 0;
  int failures = 0;

  dmem_store_buffer dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_re   (cpu_re),
    .cpu_addr (cpu_addr),
    .cpu_wd   (cpu_wd),
    .cpu_rd   (cpu_rd),
    .stall    (stall),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .empty    (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rd = dmem[mem_addr];

  // dmem model: synchronous write, asynchronous read
  always @(posedge clock) begin
    if (reset && mem_we) dmem[mem_addr] <= mem_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT writes dmem or answers a load
  always @(negedge clock) begin
    if (reset) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_addr", {22'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_addr", {22'd0, mem_addr}, {22'd0, w.a});
          chk("write_data", mem_wd, w.d);
        end
      end
      if (cpu_re) begin
        chk("load_no_mem_we", {31'd0, mem_we}, 32'd0);
        if (exp_rd.size() == 0) begin
          chk("unexpected_load", cpu_rd, 32'hFFFF_FFFF);
        end else begin
          chk("load_data", cpu_rd, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic do_idle();
    @(posedge clock); #1;
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [9:0] a, input logic [31:0] d,
                          input logic exp_stall, input logic push);
    @(posedge clock); #1;
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = a; cpu_wd = d;
    if (push) exp_wr.push_back('{a, d});
    #1;
    chk("stall_first", {31'd0, stall}, {31'd0, exp_stall});
    if (stall) begin
      @(posedge clock); #1;
      chk("stall_release", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic do_load(input logic [9:0] a, input logic [31:0] exp);
    @(posedge clock); #1;
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = a;
    exp_rd.push_back(exp);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    do_idle();
    while (!empty && n < 12) begin
      do_idle();
      n++;
    end
    chk("drain_to_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
    dmem[10'h010] = 32'h0000_5555;
    dmem[10'h3FF] = 32'h00C0_FFEE;
    reset = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 10'h0; cpu_wd = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b1;

    // Test 1: reset with three pending stores discards them
    do_store(10'h100, 32'hAAAA_0001, 1'b0, 1'b0);
    do_store(10'h101, 32'hAAAA_0002, 1'b0, 1'b0);
    do_store(10'h102, 32'hAAAA_0003, 1'b0, 1'b0);
    @(posedge clock); #1;
    cpu_we = 1'b0;
    chk("pending_not_empty", {31'd0, empty}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrun_reset_empty", {31'd0, empty}, 32'd1);
    chk("midrun_reset_mem_we", {31'd0, mem_we}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    wait_empty();
    repeat (3) do_idle();

    // Test 2: store then idle drains
    do_store(10'h0A5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_idle();
    do_idle();
    chk("store_idle_empty", {31'd0, empty}, 32'd1);

    // Test 3: forwarding of youngest store
    do_store(10'h010, 32'h0000_1111, 1'b0, 1'b1);
    do_store(10'h010, 32'h0000_2222, 1'b0, 1'b1);
    do_load(10'h010, 32'h0000_2222);
    #1;
    chk("dmem_still_old", dmem[10'h010], 32'h0000_5555);
    wait_empty();

    // Test 4: full buffer stalls the fifth store for one cycle
    do_store(10'h000, 32'h0000_0A00, 1'b0, 1'b1);
    do_store(10'h001, 32'h0000_0A01, 1'b0, 1'b1);
    do_store(10'h002, 32'h0000_0A02, 1'b0, 1'b1);
    do_store(10'h003, 32'h0000_0A03, 1'b0, 1'b1);
    do_store(10'h004, 32'h0000_0A04, 1'b1, 1'b1);
    do_load(10'h004, 32'h0000_0A04);
    wait_empty();

    // Test 5: load miss reads dmem
    do_load(10'h3FF, 32'h00C0_FFEE);
    do_idle();

    // Test 6: duplicate-address stores
    do_store(10'h020, 32'h0000_00A1, 1'b0, 1'b1);
    do_store(10'h021, 32'h0000_00B2, 1'b0, 1'b0);
`ifdef STORE_COALESCE_EN
    do_store(10'h021, 32'h0000_00C3, 1'b0, 1'b1);
`else
    exp_wr.push_back('{10'h021, 32'h0000_00B2});
    do_store(10'h021, 32'h0000_00C3, 1'b0, 1'b1);
`endif
    do_load(10'h021, 32'h0000_00C3);
    do_load(10'h020, 32'h0000_00A1);
    wait_empty();
    repeat (2) do_idle();

    chk("exp_wr_drained", exp_wr.size(), 32'd0);
    chk("exp_rd_drained", exp_rd.size(), 32'd0);
    chk("final_dmem_021", dmem[10'h021], 32'h0000_00C3);
    chk("final_dmem_0A5", dmem[10'h0A5], 32'hDEAD_BEEF);
    chk("final_dmem_010", dmem[10'h010], 32'h0000_2222);
    chk("final_dmem_004", dmem[10'h004], 32'h0000_0A04);
    chk("discarded_100", dmem[10'h100], 32'h0);
    chk("discarded_102", dmem[10'h102], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
